// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default phase lengths and mode selectors
// for the counter_param family.
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PHASE_WIDTH    = 4;
  localparam int PHASE_TERMINAL = 7;
  localparam int PHASE_OUT_AT   = 3;

  localparam int MODE_ONESHOT  = 0;
  localparam int MODE_WRAP     = 1;
  localparam int MODE_NO_ABORT = 0;
  localparam int MODE_ABORT    = 1;

endpackage

`default_nettype wire

// File: rtl/counter_param.sv
// counter_param: parametrised phase counter (0..TERMINAL) with threshold flag,
// start/clear handshake, optional abort, done pulse and busy flag.
`default_nettype none

module counter_param
  import timer_pkg::*;
#(
  parameter int WIDTH    = PHASE_WIDTH,
  parameter int TERMINAL = PHASE_TERMINAL,
  parameter int OUT_AT   = PHASE_OUT_AT,
  parameter int WRAP     = MODE_ONESHOT,
  parameter int ABORT    = MODE_NO_ABORT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             out,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 1 || TERMINAL >= (1 << WIDTH) || OUT_AT > TERMINAL || OUT_AT < 0)
  begin : g_bad_params
    $fatal(1, "counter_param: illegal WIDTH/TERMINAL/OUT_AT combination");
  end

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] OUT_V  = WIDTH'(OUT_AT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_e           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             out_n;
  logic             done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      out   <= out_n;
      busy  <= (state_n == ST_RUN);
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    out_n   = out;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        count_n = '0;
        out_n   = 1'b0;
        if (start && !clear) state_n = ST_RUN;
      end
      ST_RUN: begin
        if ((ABORT != 0) && clear) begin
          state_n = ST_IDLE;
          count_n = '0;
          out_n   = 1'b0;
        end else begin
          // Threshold is watched every RUN edge, whether or not en ticks.
          if (count == OUT_V) out_n = 1'b1;
          if (en) begin
            if (count == TERM_V) begin
              done_n = 1'b1;
              if (WRAP != 0) begin
                count_n = '0;
                out_n   = 1'b0;
              end else begin
                state_n = ST_DONE;
              end
            end else begin
              count_n = count + ONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_n = ST_IDLE;
          count_n = '0;
          out_n   = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
        out_n   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_param.sv
// tb_counter_param: directed checks of counter_param in one-shot, wrap,
// abort and OUT_AT == TERMINAL configurations.
`default_nettype none

module tb_counter_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] start = '0;
  logic [3:0] clear = '0;
  logic [3:0] en    = '0;

  logic [3:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic [3:0] out_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: defaults (T=7, OUT_AT=3, one-shot, no abort)
  counter_param u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .clear(clear[0]), .en(en[0]),
    .count(cnt0), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  // 1: wrap mode, T=5, OUT_AT=2
  counter_param #(.WIDTH(4), .TERMINAL(5), .OUT_AT(2), .WRAP(1), .ABORT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .clear(clear[1]), .en(en[1]),
    .count(cnt1), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  // 2: abort enabled
  counter_param #(.WIDTH(4), .TERMINAL(7), .OUT_AT(3), .WRAP(0), .ABORT(1)) u_abort (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .clear(clear[2]), .en(en[2]),
    .count(cnt2), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // 3: OUT_AT == TERMINAL in a 2-bit counter
  counter_param #(.WIDTH(2), .TERMINAL(3), .OUT_AT(3), .WRAP(0), .ABORT(0)) u_edge (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .clear(clear[3]), .en(en[3]),
    .count(cnt3), .out(out_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_out",   32'(out_v), 0);
    chk("rst_busy",  32'(busy_v), 0);
    chk("rst_done",  32'(done_v), 0);
    rst_n = 1'b1;
    tick();

    // ---- one-shot run with defaults
    start[0] = 1'b1;
    tick();
    chk("os_enter_busy",  32'(busy_v[0]), 1);
    chk("os_enter_count", 32'(cnt0), 0);
    start[0] = 1'b0;
    en[0]    = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("os_count", 32'(cnt0), 32'(k));
      chk("os_out",   32'(out_v[0]), (k >= 4) ? 1 : 0);
      chk("os_done",  32'(done_v[0]), 0);
    end
    tick();
    chk("os_term_done",  32'(done_v[0]), 1);
    chk("os_term_busy",  32'(busy_v[0]), 0);
    chk("os_term_count", 32'(cnt0), 7);
    tick();
    chk("os_done_pulse", 32'(done_v[0]), 0);
    chk("os_hold_count", 32'(cnt0), 7);
    chk("os_hold_out",   32'(out_v[0]), 1);
    start[0] = 1'b1;
    tick();
    chk("done_start_ign_busy",  32'(busy_v[0]), 0);
    chk("done_start_ign_count", 32'(cnt0), 7);
    start[0] = 1'b0;
    clear[0] = 1'b1;
    tick();
    chk("clr_count", 32'(cnt0), 0);
    chk("clr_out",   32'(out_v[0]), 0);
    chk("clr_busy",  32'(busy_v[0]), 0);
    start[0] = 1'b1;
    tick();
    chk("clr_beats_start", 32'(busy_v[0]), 0);
    tick();
    chk("clr_beats_start2", 32'(busy_v[0]), 0);
    start[0] = 1'b0;
    clear[0] = 1'b0;
    en[0]    = 1'b0;

    // ---- wrap mode: period of 6 edges
    start[1] = 1'b1;
    tick();
    chk("wr_enter_busy", 32'(busy_v[1]), 1);
    start[1] = 1'b0;
    en[1]    = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("wr_count", 32'(cnt1), 32'(k % 6));
      chk("wr_done",  32'(done_v[1]), (k % 6 == 0) ? 1 : 0);
      chk("wr_out",   32'(out_v[1]), (k % 6 >= 3) ? 1 : 0);
      chk("wr_busy",  32'(busy_v[1]), 1);
    end
    en[1] = 1'b0;

    // ---- en toggled 1010...; out follows count==OUT_AT, not en
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    begin
      logic [3:0] exp_c [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
      logic       exp_o [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
      for (int j = 0; j < 8; j++) begin
        en[0] = (j % 2 == 0);
        tick();
        chk("tg_count", 32'(cnt0), 32'(exp_c[j]));
        chk("tg_out",   32'(out_v[0]), 32'(exp_o[j]));
      end
    end
    // clear ignored in RUN with ABORT=0
    en[0]    = 1'b1;
    clear[0] = 1'b1;
    tick();
    chk("na_clear_count", 32'(cnt0), 5);
    chk("na_clear_busy",  32'(busy_v[0]), 1);
    clear[0] = 1'b0;
    tick();
    tick();
    chk("na_reach7", 32'(cnt0), 7);
    clear[0] = 1'b1;
    tick();
    chk("na_term_clr_done", 32'(done_v[0]), 1);
    chk("na_term_clr_busy", 32'(busy_v[0]), 0);
    chk("na_term_clr_cnt",  32'(cnt0), 7);
    clear[0] = 1'b0;
    tick();
    chk("na_clr_not_kept", 32'(cnt0), 7);
    clear[0] = 1'b1;
    tick();
    chk("na_to_idle", 32'(cnt0), 0);
    clear[0] = 1'b0;
    en[0]    = 1'b0;

    // ---- abort mode
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    en[2]    = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("ab_pre_count", 32'(cnt2), 4);
    chk("ab_pre_out",   32'(out_v[2]), 1);
    clear[2] = 1'b1;
    tick();
    chk("ab_count", 32'(cnt2), 0);
    chk("ab_out",   32'(out_v[2]), 0);
    chk("ab_busy",  32'(busy_v[2]), 0);
    chk("ab_done",  32'(done_v[2]), 0);
    clear[2] = 1'b0;
    tick();
    chk("ab_stay_idle", 32'(busy_v[2]), 0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("ab_at_term", 32'(cnt2), 7);
    clear[2] = 1'b1;
    tick();
    chk("ab_term_done",  32'(done_v[2]), 0);
    chk("ab_term_count", 32'(cnt2), 0);
    chk("ab_term_busy",  32'(busy_v[2]), 0);
    clear[2] = 1'b0;
    en[2]    = 1'b0;

    // ---- OUT_AT == TERMINAL: out rises with the DONE entry
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    en[3]    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("bd_count", 32'(cnt3), 32'(k));
      chk("bd_out",   32'(out_v[3]), 0);
    end
    tick();
    chk("bd_done",  32'(done_v[3]), 1);
    chk("bd_out_r", 32'(out_v[3]), 1);
    chk("bd_count_hold", 32'(cnt3), 3);
    en[3] = 1'b0;

    // ---- asynchronous reset mid-RUN
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    en[0]    = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("ar_pre_count", 32'(cnt0), 5);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(cnt0), 0);
    chk("ar_out",   32'(out_v[0]), 0);
    chk("ar_busy",  32'(busy_v[0]), 0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("ar_idle_count", 32'(cnt0), 0);
    chk("ar_idle_busy",  32'(busy_v[0]), 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("ar_restart_busy", 32'(busy_v[0]), 1);
    tick();
    chk("ar_restart_count", 32'(cnt0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor of the 0..7 phase counter used in the microwave control path.
- Counts 0..TERMINAL on `clk` while enabled and raises `out` once a programmable threshold is passed.
- Holds at terminal until cleared, or wraps in free-running mode.
- Adds an explicit start/clear handshake, optional abort, a done pulse and a busy flag.
- Instantiated by the timing controller to sequence heating phases and beeper cadence.

Parameters:
- WIDTH, 4: count register width; TERMINAL must be < 2**WIDTH.
- TERMINAL, 7: last count value.
- OUT_AT, 3: `out` sets on the edge where count == OUT_AT; must be <= TERMINAL.
- WRAP, 0: 0 = one-shot (stop at TERMINAL); 1 = wrap TERMINAL -> 0 and keep running.
- ABORT, 0: 0 = `clear` honoured only in DONE; 1 = `clear` also aborts RUN.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous reset, active-low.
- start, input, 1: synchronous start request; level sampled each edge.
- clear, input, 1: synchronous clear request, active-high.
- en, input, 1: count enable (tick qualifier).
- count, output, WIDTH: current count.
- out, output, 1: threshold flag.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse at terminal (stop or wrap).

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, count = 0, out = 0, done = 0, busy = 0.
  - Release is synchronous to the next rising edge.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start = 1 and clear = 0 -> RUN next edge; count stays 0, out = 0.
  - clear in IDLE: no effect.
- RUN:
  - busy = 1.
  - Each edge with en = 1 and count < TERMINAL: count <= count + 1.
  - en = 0: count holds.
  - Edge with en = 1 and count == TERMINAL:
    - WRAP = 0: count holds at TERMINAL, state -> DONE, done = 1 for one cycle.
    - WRAP = 1: count <= 0, out <= 0, stay RUN, done = 1 for one cycle.
  - start while in RUN: ignored (no retrigger).
  - clear with ABORT = 1 -> IDLE next edge: count = 0, out = 0, no done pulse.
  - clear with ABORT = 0: ignored.
- DONE:
  - busy = 0; count holds TERMINAL; out holds.
  - clear -> IDLE next edge: count = 0, out = 0.
  - start without clear: ignored.
- out:
  - Set on any edge in RUN where count == OUT_AT, independent of en.
  - So out rises one cycle after count first equals OUT_AT.
  - Cleared only on return to IDLE, on wrap, or on reset.
  - Boundary OUT_AT == TERMINAL: out rises on the same edge that enters DONE (or on the wrap edge; wrap-clear wins, so out stays 0 in WRAP = 1).
- Simultaneous events:
  - clear beats start.
  - A terminal edge with clear in RUN and ABORT = 1: abort wins, no done pulse.
  - A terminal edge with clear and ABORT = 0: normal terminal behaviour; clear is not remembered.
- Arithmetic: unsigned WIDTH-bit; count never exceeds TERMINAL; no implicit overflow.
- Elaboration checks: fatal if TERMINAL >= 2**WIDTH, OUT_AT > TERMINAL, or WIDTH < 1.

Decomposition:
- Shared package `timer_pkg`:
  - state enum for IDLE, RUN and DONE.
  - Default constants for phase lengths (e.g. `PHASE_TERMINAL = 7`, `PHASE_OUT_AT = 3`).
  - Mode constants for WRAP and ABORT.
- No sub-module; single FSM plus counter datapath.
- The controller instantiates several copies with different parameters.

Test Plan:
- Defaults, start pulse, en = 1 every cycle:
  - count steps 0..7 over 7 edges after RUN entry.
  - out rises the edge after count = 3 (count = 4).
  - done pulses once as DONE is entered; busy falls; count holds 7.
- DONE then clear = 1 for one cycle:
  - IDLE next edge, count = 0, out = 0.
  - start with clear high simultaneously: stays IDLE.
- WRAP = 1, TERMINAL = 5, OUT_AT = 2, en = 1:
  - count cycles 0..5,0..; done pulses every 6 edges.
  - out high from count = 3 through the wrap edge, then low.
- en toggled 1010...: count advances only on en edges; out timing tracks count == OUT_AT, not en.
- ABORT = 1, clear at count = 4: IDLE next edge, count = 0, out = 0, no done. Same with ABORT = 0: clear ignored, reaches 7.
- rst_n asserted mid-RUN at count = 5, asynchronous to clk: count/out/busy go 0 immediately; no activity until the next start after release.
